// File: rtl/timer_pkg.sv
// timer_pkg: shared state encodings and default count limits for the countdown timer
package timer_pkg;
  localparam int MAX_MIN_DEF = 99;
  localparam int MAX_SEC_DEF = 59;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control, preset and status bundle of the countdown timer
interface countdown_timer_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       load;
  logic       clear;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic [1:0] state;
  logic       expired;
  modport master (output tick, start, stop, load, clear, preset_min, preset_sec,
                  input minutes, seconds, state, expired);
  modport slave  (input tick, start, stop, load, clear, preset_min, preset_sec,
                  output minutes, seconds, state, expired);
endinterface

// File: rtl/down_digit.sv
// down_digit: loadable modulo-(MAX+1) down-counter with clamped load, borrow chain and zero flag
module down_digit #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [7:0] ld_val,
  input  logic       borrow_in,
  output logic [7:0] q,
  output logic       borrow_out,
  output logic       zero
);
  assign zero       = q == 8'd0;
  assign borrow_out = borrow_in && zero;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (ld) q <= ld_val > 8'(MAX) ? 8'(MAX) : ld_val;
    else if (borrow_in) q <= zero ? 8'(MAX) : q - 8'd1;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss countdown with load/start/stop/clear control and one-cycle expiry pulse
module countdown_timer
  import timer_pkg::*;
#(
  parameter int MAX_MIN = MAX_MIN_DEF,
  parameter int MAX_SEC = MAX_SEC_DEF
) (
  input logic              clk,
  input logic              rst_n,
  countdown_timer_if.slave bus
);
  state_t     state_q, state_d;
  logic [7:0] sec_q, min_q;
  logic       dec, load_ok, hit, sec_bo, min_bo, sec_zero, min_zero, cnt_zero, expired_q;
  // load is locked out while running; an accepted stop swallows a coincident tick
  assign load_ok  = bus.load && state_q != RUN && !bus.clear;
  assign dec      = state_q == RUN && bus.tick && !bus.clear && !bus.stop;
  assign cnt_zero = sec_zero && min_zero;
  assign hit      = dec && min_zero && sec_q == 8'd1;
  down_digit #(.MAX(MAX_SEC)) u_sec (
    .clk, .rst_n, .clr(bus.clear), .ld(load_ok), .ld_val(bus.preset_sec),
    .borrow_in(dec), .q(sec_q), .borrow_out(sec_bo), .zero(sec_zero)
  );
  down_digit #(.MAX(MAX_MIN)) u_min (
    .clk, .rst_n, .clr(bus.clear), .ld(load_ok), .ld_val(bus.preset_min),
    .borrow_in(sec_bo), .q(min_q), .borrow_out(min_bo), .zero(min_zero)
  );
  always_comb
    state_d = (bus.clear || load_ok)                                        ? IDLE  :
              (bus.stop && state_q == RUN)                                  ? PAUSE :
              (bus.start && (state_q == IDLE || state_q == PAUSE) && !cnt_zero) ? RUN :
              (hit || min_bo)                                               ? DONE  : state_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      expired_q <= hit;
    end
  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.state   = state_q;
  assign bus.expired = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven directed checks of the countdown timer plus reset/expiry sequences
module tb_countdown_timer;
  localparam logic [4:0] N = 5'b00000, T = 5'b10000, S = 5'b01000, P = 5'b00100,
                         L = 5'b00010, C = 5'b00001;
  localparam int I_ = 0, R_ = 1, P_ = 2, D_ = 3;
  typedef struct {
    logic [4:0] ctl;
    logic [7:0] pm, ps, em, es;
    logic [1:0] est;
    logic       eexp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0;
  vec_t vecs[$];
  countdown_timer_if tif ();
  countdown_timer dut (.clk(clk), .rst_n(rst_n), .bus(tif.slave));
  always #5 clk = ~clk;
  function automatic vec_t v(input logic [4:0] ctl, input int pm, ps, em, es, est, ex);
    v = '{ctl, 8'(pm), 8'(ps), 8'(em), 8'(es), 2'(est), 1'(ex)};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int em, es, est, ex);
    chk({tag, " minutes"}, 32'(tif.minutes), em);
    chk({tag, " seconds"}, 32'(tif.seconds), es);
    chk({tag, " state"}, 32'(tif.state), est);
    chk({tag, " expired"}, 32'(tif.expired), ex);
  endtask
  task automatic apply(input logic [4:0] ctl, input int pm, ps);
    @(negedge clk);
    {tif.tick, tif.start, tif.stop, tif.load, tif.clear} = ctl;
    tif.preset_min = 8'(pm);
    tif.preset_sec = 8'(ps);
    @(posedge clk);
    #1;
  endtask
  initial begin
    {tif.tick, tif.start, tif.stop, tif.load, tif.clear} = N;
    tif.preset_min = 8'd0;
    tif.preset_sec = 8'd0;
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0, 0, I_, 0);
    @(negedge clk) rst_n = 1'b1;
    apply(L, 1, 0);
    chk_all("load 01:00", 1, 0, I_, 0);
    apply(S, 0, 0);
    chk_all("start", 1, 0, R_, 0);
    apply(T, 0, 0);
    chk_all("borrow 00:59", 0, 59, R_, 0);
    for (int i = 58; i >= 1; i--) begin
      apply(T, 0, 0);
      chk("run seconds", 32'(tif.seconds), i);
      chk("run expired", 32'(tif.expired), 0);
    end
    apply(T, 0, 0);
    chk_all("expire", 0, 0, D_, 1);
    apply(N, 0, 0);
    chk_all("expire one cycle", 0, 0, D_, 0);
    vecs.push_back(v(S,      0,  0, 0,  0, D_, 0));
    vecs.push_back(v(L,    150, 75, 99, 59, I_, 0));
    vecs.push_back(v(C,      0,  0, 0,  0, I_, 0));
    vecs.push_back(v(S,      0,  0, 0,  0, I_, 0));
    vecs.push_back(v(L,      0,  5, 0,  5, I_, 0));
    vecs.push_back(v(S,      0,  0, 0,  5, R_, 0));
    vecs.push_back(v(T,      0,  0, 0,  4, R_, 0));
    vecs.push_back(v(T,      0,  0, 0,  3, R_, 0));
    vecs.push_back(v(P | T,  0,  0, 0,  3, P_, 0));
    vecs.push_back(v(T,      0,  0, 0,  3, P_, 0));
    vecs.push_back(v(T,      0,  0, 0,  3, P_, 0));
    vecs.push_back(v(T,      0,  0, 0,  3, P_, 0));
    vecs.push_back(v(P,      0,  0, 0,  3, P_, 0));
    vecs.push_back(v(S | T,  0,  0, 0,  3, R_, 0));
    vecs.push_back(v(T,      0,  0, 0,  2, R_, 0));
    vecs.push_back(v(P,      0,  0, 0,  2, P_, 0));
    vecs.push_back(v(L,      0,  3, 0,  3, I_, 0));
    vecs.push_back(v(S,      0,  0, 0,  3, R_, 0));
    vecs.push_back(v(C | T,  0,  0, 0,  0, I_, 0));
    vecs.push_back(v(N,      0,  0, 0,  0, I_, 0));
    vecs.push_back(v(L,      2,  0, 2,  0, I_, 0));
    vecs.push_back(v(S,      0,  0, 2,  0, R_, 0));
    vecs.push_back(v(L | T, 10,  0, 1, 59, R_, 0));
    vecs.push_back(v(T,      0,  0, 1, 58, R_, 0));
    vecs.push_back(v(L | P,  0,  1, 1, 58, P_, 0));
    vecs.push_back(v(L,      0,  1, 0,  1, I_, 0));
    vecs.push_back(v(S,      0,  0, 0,  1, R_, 0));
    vecs.push_back(v(T | S,  0,  0, 0,  0, D_, 1));
    vecs.push_back(v(L,      3,  0, 3,  0, I_, 0));
    vecs.push_back(v(L,      0,  0, 0,  0, I_, 0));
    vecs.push_back(v(S | T,  0,  0, 0,  0, I_, 0));
    vecs.push_back(v(L,    255, 60, 99, 59, I_, 0));
    vecs.push_back(v(C | L,  5,  5, 0,  0, I_, 0));
    foreach (vecs[k]) begin
      apply(vecs[k].ctl, vecs[k].pm, vecs[k].ps);
      chk_all($sformatf("vec%0d", k), vecs[k].em, vecs[k].es, vecs[k].est, vecs[k].eexp);
    end
    apply(L, 2, 31);
    apply(S, 0, 0);
    apply(T, 0, 0);
    chk_all("pre-reset 02:30", 2, 30, R_, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("async reset", 0, 0, I_, 0);
    @(negedge clk) {tif.tick, tif.start} = 2'b11;
    @(posedge clk);
    #1 chk_all("held in reset", 0, 0, I_, 0);
    @(negedge clk) rst_n = 1'b1;
    apply(T, 0, 0);
    chk_all("tick after reset", 0, 0, I_, 0);
    apply(S, 0, 0);
    chk_all("start after reset", 0, 0, I_, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
